// File: rtl/adc_tx_pkg.sv
// adc_tx_pkg: shared constants and types for the ADC serial-output emulator.
//   BITS_PER_LANE : serial bits per lane per frame (MSB first)
//   NUM_LANES     : number of serial data lanes
//   SAMPLE_W      : parallel sample width (NUM_LANES * BITS_PER_LANE)
//   IDLE_WORD_DEF : default word sent when no sample is buffered at LOAD
package adc_tx_pkg;
   localparam int BITS_PER_LANE = 6;
   localparam int NUM_LANES     = 2;
   localparam int SAMPLE_W      = NUM_LANES * BITS_PER_LANE;
   localparam int CNT_W         = $clog2(BITS_PER_LANE);

   localparam logic [SAMPLE_W-1:0] IDLE_WORD_DEF = 12'h9A5;

   typedef enum logic {IDLE, RUN} tx_state_e;

   // Lane-major view of a sample: word[1] = sample[11:6], word[0] = sample[5:0].
   typedef logic [NUM_LANES-1:0][BITS_PER_LANE-1:0] lane_word_t;
endpackage

// File: rtl/adc_tx_lane_shifter.sv
// adc_tx_lane_shifter: one serial lane, parallel load then MSB-first shift.
//   adc_dclk, rst_n : bit clock, async active-low reset
//   clr             : zero the register (stop/idle), highest priority
//   load, din       : parallel load of the next frame's bits
//   shift           : advance one bit; with no control asserted the bit holds
//   dout            : current serial bit (register MSB)
module adc_tx_lane_shifter #(
   parameter int W = 6
) (
   input  logic         adc_dclk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic         dout
);
   logic [W-1:0] sr;

   always_ff @(posedge adc_dclk or negedge rst_n) begin
      if (!rst_n)      sr <= '0;
      else if (clr)    sr <= '0;
      else if (load)   sr <= din;
      else if (shift)  sr <= {sr[W-2:0], 1'b0};
   end

   assign dout = sr[W-1];
endmodule

// File: rtl/adc_lvds_tx_emulator.sv
// adc_lvds_tx_emulator: emulates the 2-lane ADC serial output (12-bit sample,
// 6 bits per lane, MSB first, SDR) plus frame clock, for receiver loopback.
//   adc_dclk, rst_n           : bit clock, async active-low reset
//   enable                    : start; deassert finishes the current frame
//   sample/sample_valid/ready : 1-entry holding buffer input handshake
//   slip                      : hold bit counter and shifters for one cycle
//   lane_d[1:0], fclk_out     : serial lanes and frame clock (high slots 0-2)
//   busy                      : FSM in RUN
//   underflow, underflow_cnt  : idle-word insertion pulse / saturating count
// Optional: define ADC_TX_PATTERN_EN to add pattern_sel, which replaces the
// buffer with an internal 12-bit ramp at every LOAD.
module adc_lvds_tx_emulator
   import adc_tx_pkg::*;
#(
   parameter logic [SAMPLE_W-1:0] IDLE_WORD   = IDLE_WORD_DEF,
   parameter int                  UFLOW_CNT_W = 16
) (
   input  logic                   adc_dclk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [SAMPLE_W-1:0]    sample,
   input  logic                   sample_valid,
   input  logic                   slip,
`ifdef ADC_TX_PATTERN_EN
   input  logic                   pattern_sel,
`endif
   output logic                   sample_ready,
   output logic [NUM_LANES-1:0]   lane_d,
   output logic                   fclk_out,
   output logic                   busy,
   output logic                   underflow,
   output logic [UFLOW_CNT_W-1:0] underflow_cnt
);
   tx_state_e        state, nxt_state;
   logic [CNT_W-1:0] bit_cnt, nxt_cnt;
   logic             load_now, clr_now, shift_now;
   logic             buf_full, accept, pat_on;
   lane_word_t       hold_buf, load_word;

`ifdef ADC_TX_PATTERN_EN
   logic [SAMPLE_W-1:0] ramp;
   assign pat_on = pattern_sel;
`else
   assign pat_on = 1'b0;
`endif

   // Frame sequencing. A slip freezes everything for one cycle; when it lands
   // on the last slot, the LOAD is simply deferred.
   always_comb begin
      nxt_state = state;
      nxt_cnt   = bit_cnt;
      load_now  = 1'b0;
      clr_now   = 1'b0;
      shift_now = 1'b0;
      case (state)
         IDLE: begin
            if (enable) begin
               load_now  = 1'b1;
               nxt_state = RUN;
               nxt_cnt   = '0;
            end
         end
         RUN: begin
            if (!slip) begin
               if (bit_cnt == CNT_W'(BITS_PER_LANE-1)) begin
                  nxt_cnt = '0;
                  if (enable) begin
                     load_now = 1'b1;
                  end else begin
                     clr_now   = 1'b1;
                     nxt_state = IDLE;
                  end
               end else begin
                  shift_now = 1'b1;
                  nxt_cnt   = bit_cnt + 1'b1;
               end
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

   // The buffer refills in the LOAD cycle but its new content is not
   // forwarded: an empty buffer at LOAD always sends the idle word.
   always_comb begin
      load_word = buf_full ? hold_buf : lane_word_t'(IDLE_WORD);
`ifdef ADC_TX_PATTERN_EN
      if (pattern_sel) load_word = lane_word_t'(ramp);
`endif
   end

   assign sample_ready = ~pat_on & (~buf_full | load_now);
   assign accept       = sample_valid & sample_ready;
   assign busy         = (state == RUN);

   always_ff @(posedge adc_dclk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         bit_cnt       <= '0;
         fclk_out      <= 1'b0;
         hold_buf      <= '0;
         buf_full      <= 1'b0;
         underflow     <= 1'b0;
         underflow_cnt <= '0;
      end else begin
         state     <= nxt_state;
         bit_cnt   <= nxt_cnt;
         // Registered so it lines up with the shifter MSB for the same slot.
         fclk_out  <= (nxt_state == RUN) && (nxt_cnt < CNT_W'(BITS_PER_LANE/2));
         underflow <= load_now & ~pat_on & ~buf_full;
         if (accept) begin
            hold_buf <= sample;
            buf_full <= 1'b1;
         end else if (load_now && !pat_on) begin
            buf_full <= 1'b0;
         end
         if (load_now && !pat_on && !buf_full && (underflow_cnt != '1))
            underflow_cnt <= underflow_cnt + 1'b1;
      end
   end

`ifdef ADC_TX_PATTERN_EN
   always_ff @(posedge adc_dclk or negedge rst_n) begin
      if (!rst_n)                      ramp <= '0;
      else if (load_now && pattern_sel) ramp <= ramp + 1'b1;
   end
`endif

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      adc_tx_lane_shifter #(.W(BITS_PER_LANE)) u_shf (
         .adc_dclk (adc_dclk),
         .rst_n    (rst_n),
         .clr      (clr_now),
         .load     (load_now),
         .shift    (shift_now),
         .din      (load_word[g]),
         .dout     (lane_d[g])
      );
   end
endmodule
